// File: rtl/prog_loader.sv
// Boot-time program loader: turns a length-prefixed little-endian byte stream into RAM word writes.
// Optional trailer checksum check is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_SIZE  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic [31:0] words_loaded,
    output logic        done,
    output logic        err,
    output logic [2:0]  o_dbg_state
);

    localparam logic [31:0] MAX_WORDS = 32'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CHK = 3'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      r_state_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_len;
    logic [31:0] r_idx;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wd;
    logic        w_ready_st;
    logic        w_xfer;
    logic        w_byte_last;
    logic [31:0] w_word_next;
    logic        w_last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    // Valid/ready: a byte moves on a rising edge with in_valid & in_ready both high;
    // in_ready depends only on state (and is forced low while rst is held).
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_ready_st = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_ready_st = (r_state == S_LEN) || (r_state == S_DATA);
`endif
    assign in_ready    = w_ready_st & ~rst;
    assign w_xfer      = in_valid & w_ready_st;
    assign w_byte_last = (r_cnt == 2'd3);
    assign w_word_next = {in_data, r_shift[31:8]};
    assign w_last_word = ((r_idx + 32'd1) == r_len);

    assign mem_addr     = r_mem_addr;
    assign mem_wd       = r_mem_wd;
    assign words_loaded = r_idx;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LEN;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        mem_we       = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_LEN: begin
                if (w_xfer && w_byte_last) begin
                    if (w_word_next == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state_next = S_CHK;
`else
                        r_state_next = S_DONE;
`endif
                    end else if (w_word_next > MAX_WORDS) begin
                        r_state_next = S_ERR;
                    end else begin
                        r_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && w_byte_last) begin
                    r_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (w_last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    r_state_next = S_CHK;
`else
                    r_state_next = S_DONE;
`endif
                end else begin
                    r_state_next = S_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer && w_byte_last) begin
                    r_state_next = (w_word_next == r_sum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: r_state_next = S_ERR;
        endcase
    end

    // Address and data are captured with the word's last byte so they are stable for the whole write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 2'd0;
            r_shift    <= 32'd0;
            r_len      <= 32'd0;
            r_idx      <= 32'd0;
            r_mem_addr <= 32'd0;
            r_mem_wd   <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            if (w_xfer) begin
                r_shift <= w_word_next;
                r_cnt   <= r_cnt + 2'd1;
                if (w_byte_last && (r_state == S_LEN)) begin
                    r_len <= w_word_next;
                end
                if (w_byte_last && (r_state == S_DATA)) begin
                    r_mem_addr <= BASE_ADDR + {r_idx[29:0], 2'b00};
                    r_mem_wd   <= w_word_next;
                end
            end
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum <= r_sum + r_mem_wd;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios with a write scoreboard.
// Define PROG_LOADER_CHECKSUM_EN for both files to exercise the trailer checksum path.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] words_loaded;
    logic        done;
    logic        err;
    logic [2:0]  o_dbg_state;

    localparam logic [31:0] BASE = 32'h8000_0000;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(BASE), .MEM_SIZE(4096)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
        .words_loaded(words_loaded), .done(done), .err(err), .o_dbg_state(o_dbg_state)
    );

    logic [63:0] exp_q[$];
    logic [31:0] img[$];
    logic [31:0] widx;
    logic [31:0] model_sum;
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (!rst && mem_we === 1'b1) begin
            logic [63:0] e;
            wr_cnt++;
            check("write_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wd, e[31:0]);
                check("ready_in_write", in_ready, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_words", words_loaded, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        widx = 32'd0;
        model_sum = 32'd0;
        wr_cnt = 0;
        #1;
        check("post_rst_ready", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        @(negedge clk);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[7:0], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[31:24], gaps);
    endtask

    task automatic load_words(input bit gaps);
        logic [31:0] w;
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            send_byte(w[7:0], gaps);
            send_byte(w[15:8], gaps);
            send_byte(w[23:16], gaps);
            exp_q.push_back({BASE + (widx << 2), w});
            widx = widx + 32'd1;
            model_sum = model_sum + w;
            send_byte(w[31:24], gaps);
            check("we_latency", mem_we, 1);
            check("done_during_write", done, 0);
        end
    endtask

    // Brings the loader from its last write to S_DONE (via a correct trailer when checksums are on).
    task automatic finish_image();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(model_sum, 1'b0);
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic check_done(input string tag, input logic [31:0] nwords);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_words"}, words_loaded, nwords);
        check({tag, "_wr_cnt"}, wr_cnt, nwords);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        widx = 32'd0;
        model_sum = 32'd0;

        // 1: two-word image, back-to-back bytes
        do_reset();
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        send_word(32'd2, 1'b0);
        load_words(1'b0);
        finish_image();
        check_done("s1", 32'd2);
        check("s1_last_addr", mem_addr, 32'h8000_0004);
        check("s1_last_wd", mem_wd, 32'hDEAD_BEEF);

        // 2: empty image
        do_reset();
        send_word(32'd0, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("s2_wait_trailer", done, 0);
        check("s2_chk_ready", in_ready, 1);
        send_word(32'd0, 1'b0);
`endif
        check_done("s2", 32'd0);

        // 3a: one word too long
        do_reset();
        send_word(32'h0000_0401, 1'b0);
        check("s3_err", err, 1);
        check("s3_done", done, 0);
        check("s3_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("s3_err_sticky", err, 1);
        check("s3_no_writes", wr_cnt, 0);

        // 3b: exactly fills the RAM
        do_reset();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back($urandom);
        send_word(32'h0000_0400, 1'b0);
        load_words(1'b0);
        finish_image();
        check_done("s3b", 32'd1024);
        check("s3b_last_addr", mem_addr, 32'h8000_0FFC);

        // 4: scenario 1 with random valid gaps
        do_reset();
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        send_word(32'd2, 1'b1);
        load_words(1'b1);
        finish_image();
        check_done("s4", 32'd2);

        // 5: reset after six payload bytes, then a fresh image
        do_reset();
        img = '{32'h1234_5678};
        send_word(32'd2, 1'b0);
        load_words(1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        check("s5_pre_words", words_loaded, 1);
        do_reset();
        img = '{32'hA5A5_0F0F, 32'h0102_0304, 32'hFFFF_FFFF};
        send_word(32'd3, 1'b0);
        load_words(1'b0);
        finish_image();
        check_done("s5", 32'd3);
        check("s5_last_addr", mem_addr, 32'h8000_0008);

`ifdef PROG_LOADER_CHECKSUM_EN
        // 6: explicit good and bad trailers
        do_reset();
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        send_word(32'd2, 1'b0);
        load_words(1'b0);
        check("s6_wait_trailer", done, 0);
        send_word(32'hF0E2_1567, 1'b0);
        check_done("s6_good", 32'd2);

        do_reset();
        send_word(32'd2, 1'b0);
        load_words(1'b0);
        send_word(32'h0000_0000, 1'b0);
        check("s6_bad_err", err, 1);
        check("s6_bad_done", done, 0);
        check("s6_bad_ready", in_ready, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader upstream of the core's unified RAM.
- Accepts a byte stream (e.g. from a UART receiver) with a valid/ready handshake.
- Assembles little-endian 32-bit words and drives a single RAM write port (address, write-enable, write-data) to fill memory from BASE_ADDR upward.
- Raises `done` when the image is complete. The SoC wrapper uses `done` to release core reset and to hand the RAM data port back to the core.

Parameters:
- BASE_ADDR, 32'h8000_0000: byte address of the first loaded word; equals the core's PC reset value.
- MEM_SIZE, 4096: RAM size in bytes. Maximum image length is MEM_SIZE/4 words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `in_data` holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  32  RAM byte address of the word being written.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_wd  output  32  RAM write data.
- words_loaded  output  32  count of words written so far.
- done  output  1  image fully loaded; sticky until reset.
- err  output  1  protocol error; sticky until reset.

Behaviour:
- Reset values
  - `rst` high forces all outputs to 0 and the state to S_LEN immediately (asynchronously).
  - Byte counter and word index are cleared.
  - Reset mid-load abandons the partial word. RAM contents already written are left as-is.
- Handshake
  - A byte transfers on a rising edge where `in_valid` and `in_ready` are both 1.
  - `in_ready` is combinational from state only, never from `in_valid`.
  - `in_ready` = 1 in S_LEN and S_DATA, 0 in all other states.
- Stream format
  - 4-byte length L in words, little-endian (first byte is bits 7:0).
  - Then L×4 payload bytes, each word little-endian.
- State machine
  - S_LEN
    - Collect 4 bytes into `len`.
    - On the 4th byte: if L==0 go to S_DONE; if L > MEM_SIZE/4 go to S_ERR; otherwise go to S_DATA.
  - S_DATA
    - Collect 4 bytes into the word shift register.
    - On the 4th byte go to S_WRITE.
  - S_WRITE (exactly one cycle)
    - `mem_we`=1, `mem_addr` = BASE_ADDR + 4×idx, `mem_wd` = assembled word.
    - At the end of the cycle, idx and `words_loaded` increment.
    - Next state is S_DATA, or S_DONE when idx+1 == L (S_CHK if the checksum feature is enabled).
  - S_DONE: `done`=1, `in_ready`=0; incoming bytes are ignored.
  - S_ERR: `err`=1, `in_ready`=0; incoming bytes are ignored.
- Timing
  - Latency: the 4th byte of a word accepted at edge N gives `mem_we` high during cycle N+1.
  - `done` rises the cycle after the last S_WRITE cycle.
  - Maximum throughput is 4 bytes per 5 cycles.
- Outputs outside S_WRITE
  - `mem_we`=0.
  - `mem_addr` and `mem_wd` hold their last values (0 after reset).
- Arithmetic
  - `mem_addr` is computed mod 2^32.
  - The length check is an unsigned 32-bit compare.
  - L == MEM_SIZE/4 exactly is accepted and fills the whole RAM.
- Exclusivity: `done` and `err` are never both 1.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- Defined
  - After the last S_WRITE, go to S_CHK instead of S_DONE. `in_ready`=1 in S_CHK.
  - S_CHK collects a 4-byte little-endian trailer.
  - Trailer equal to the 32-bit wrap-around sum of all L payload words → S_DONE; otherwise → S_ERR.
  - For L==0 the trailer is still required, and its expected value is 0.
- Undefined
  - No S_CHK state and no accumulator; behaviour is exactly as described above.

Test Plan:
1. Reset, then bytes 02 00 00 00, 78 56 34 12, EF BE AD DE with `in_valid` always 1 → writes 0x12345678 @0x8000_0000 and 0xDEADBEEF @0x8000_0004, one `mem_we` pulse each; `words_loaded`=2; `done`=1; `in_ready` 0 during each write cycle.
2. Length 00 00 00 00 → `done`=1 one cycle after the 4th byte; no `mem_we` (with the checksum feature enabled: after trailer 00 00 00 00).
3. Length 0x401 with MEM_SIZE=4096 → `err`=1, `in_ready`=0, no writes; length 0x400 → accepted, last write @0x8000_0FFC.
4. Random `in_valid` gaps (about 50%) on scenario 1 → identical writes and values; no byte is lost or duplicated.
5. Assert `rst` for 1 cycle after 6 payload bytes → outputs 0 immediately; a new full image then loads correctly from BASE_ADDR.
6. With PROG_LOADER_CHECKSUM_EN, scenario 1 plus trailer 67 15 E2 F0 (sum 0xF0E21567) → `done`; trailer 00 00 00 00 → `err`.
